// File: rtl/seg_disp_scan.sv
// rtl/seg_disp_scan.sv - six-digit multiplexed 7-segment scan driver with frame snapshot
//
// Scans six BCD digits one at a time. Each digit stays on for SCAN_DIV clocks.
// All inputs are captured into shadow registers once per frame, so a counter
// update part-way through a frame cannot tear the display.
//
// Ports:
//   clk        - system clock
//   rst        - synchronous reset, active-high
//   i_digits   - six BCD nibbles, [3:0] is digit0 (rightmost) .. [23:20] is digit5
//   i_dp       - decimal-point request per digit
//   i_blink    - blink enable per digit
//   i_blank_lz - 1 enables leading-zero blanking
//   o_seg_enb  - one-hot digit enable, active-high, bit n = digit n
//   o_seg_dp   - decimal point, active-high
//   o_seg      - segments {g,f,e,d,c,b,a}, active-high
//   o_frame    - one-cycle pulse after each input snapshot
module seg_disp_scan #(
    parameter int SCAN_DIV  = 50000,
    parameter int BLINK_DIV = 500
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] i_digits,
    input  logic [5:0]  i_dp,
    input  logic [5:0]  i_blink,
    input  logic        i_blank_lz,
    output logic [5:0]  o_seg_enb,
    output logic        o_seg_dp,
    output logic [6:0]  o_seg,
    output logic        o_frame
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX   = CW'(SCAN_DIV - 1);
    localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_DIV - 1);

    // Scan state
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          blink_off_q, blink_off_d;    // 0 = ON phase (reset state)

    // Per-frame shadow of the inputs
    logic [23:0]   dig_sh_q, dig_sh_d;
    logic [5:0]    dp_sh_q, dp_sh_d;
    logic [5:0]    blink_sh_q, blink_sh_d;
    logic          lz_sh_q, lz_sh_d;

    // Registered outputs
    logic [5:0]    enb_q, enb_d;
    logic          dp_q, dp_d;
    logic [6:0]    seg_q, seg_d;
    logic          frame_q, frame_d;

    logic          tick;
    logic          snap;
    logic [3:0]    cur_digit;
    logic          cur_dp;
    logic          cur_blink;
    logic          cur_zero_from;
    logic [5:0]    zero_from;   // zero_from[n]: digits n..5 are all zero

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    seg_decode = 7'h3F;
            4'd1:    seg_decode = 7'h06;
            4'd2:    seg_decode = 7'h5B;
            4'd3:    seg_decode = 7'h4F;
            4'd4:    seg_decode = 7'h66;
            4'd5:    seg_decode = 7'h6D;
            4'd6:    seg_decode = 7'h7D;
            4'd7:    seg_decode = 7'h07;
            4'd8:    seg_decode = 7'h7F;
            4'd9:    seg_decode = 7'h6F;
            default: seg_decode = 7'h40;    // non-BCD nibble shows '-'
        endcase
    endfunction

    always_comb begin
        tick = (cnt_q == CNT_MAX);
        snap = (cnt_q == '0) && (idx_q == 3'd0);

        cnt_d = tick ? '0 : cnt_q + 1'b1;

        idx_d = idx_q;
        if (tick) begin
            idx_d = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
        end

        blink_cnt_d = blink_cnt_q;
        blink_off_d = blink_off_q;
        if (tick) begin
            if (blink_cnt_q == BLINK_MAX) begin
                blink_cnt_d = '0;
                blink_off_d = ~blink_off_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
        end

        dig_sh_d   = dig_sh_q;
        dp_sh_d    = dp_sh_q;
        blink_sh_d = blink_sh_q;
        lz_sh_d    = lz_sh_q;
        if (snap) begin
            dig_sh_d   = i_digits;
            dp_sh_d    = i_dp;
            blink_sh_d = i_blink;
            lz_sh_d    = i_blank_lz;
        end
        frame_d = snap;

        zero_from[5] = (dig_sh_q[23:20] == 4'd0);
        for (int i = 4; i >= 0; i--) begin
            zero_from[i] = zero_from[i+1] && (dig_sh_q[i*4 +: 4] == 4'd0);
        end

        cur_digit     = dig_sh_q[3:0];
        cur_dp        = dp_sh_q[0];
        cur_blink     = blink_sh_q[0];
        cur_zero_from = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (idx_q == 3'(i)) begin
                cur_digit     = dig_sh_q[i*4 +: 4];
                cur_dp        = dp_sh_q[i];
                cur_blink     = blink_sh_q[i];
                cur_zero_from = zero_from[i];
            end
        end

        enb_d = 6'b000001 << idx_q;
        dp_d  = cur_dp;
        seg_d = seg_decode(cur_digit);
        // Digit0 is never blanked so an all-zero value still shows one '0'.
        if (lz_sh_q && (idx_q != 3'd0) && cur_zero_from) begin
            seg_d = 7'h00;
        end
        // Blink-off phase suppresses both segments and decimal point.
        if (blink_off_q && cur_blink) begin
            seg_d = 7'h00;
            dp_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            idx_q       <= 3'd0;
            blink_cnt_q <= '0;
            blink_off_q <= 1'b0;
            dig_sh_q    <= '0;
            dp_sh_q     <= '0;
            blink_sh_q  <= '0;
            lz_sh_q     <= 1'b0;
            enb_q       <= '0;
            dp_q        <= 1'b0;
            seg_q       <= '0;
            frame_q     <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            blink_cnt_q <= blink_cnt_d;
            blink_off_q <= blink_off_d;
            dig_sh_q    <= dig_sh_d;
            dp_sh_q     <= dp_sh_d;
            blink_sh_q  <= blink_sh_d;
            lz_sh_q     <= lz_sh_d;
            enb_q       <= enb_d;
            dp_q        <= dp_d;
            seg_q       <= seg_d;
            frame_q     <= frame_d;
        end
    end

    assign o_seg_enb = enb_q;
    assign o_seg_dp  = dp_q;
    assign o_seg     = seg_q;
    assign o_frame   = frame_q;

endmodule

// File: tb/tb_seg_disp_scan.sv
// tb/tb_seg_disp_scan.sv - randomized scoreboard bench for seg_disp_scan
module tb_seg_disp_scan;

    localparam int SD = 4;
    localparam int BD = 2;
    localparam int NCYC = 4000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [23:0] i_digits = '0;
    logic [5:0]  i_dp = '0;
    logic [5:0]  i_blink = '0;
    logic        i_blank_lz = 1'b0;
    logic [5:0]  o_seg_enb;
    logic        o_seg_dp;
    logic [6:0]  o_seg;
    logic        o_frame;

    seg_disp_scan #(.SCAN_DIV(SD), .BLINK_DIV(BD)) dut (
        .clk        (clk),
        .rst        (rst),
        .i_digits   (i_digits),
        .i_dp       (i_dp),
        .i_blink    (i_blink),
        .i_blank_lz (i_blank_lz),
        .o_seg_enb  (o_seg_enb),
        .o_seg_dp   (o_seg_dp),
        .o_seg      (o_seg),
        .o_frame    (o_frame)
    );

    always #5 clk = ~clk;

    // Expected output word: {enb[5:0], dp, seg[6:0], frame}
    logic [14:0] sb[$];
    int total = 0;
    int bad = 0;

    logic [6:0] seg_tab [16];

    // Reference model state: digits as integers, cycle count since release
    int  sh_dig [6];
    bit  sh_dp [6];
    bit  sh_blink [6];
    bit  sh_lz;
    int  n;
    logic [14:0] pending;
    bit  pending_valid;

    function automatic logic [14:0] model_out(input int idx, input bit phase_on,
                                              input bit frame);
        bit all_zero;
        logic [6:0] seg;
        bit dp;
        all_zero = 1'b1;
        for (int k = idx; k < 6; k++) if (sh_dig[k] != 0) all_zero = 1'b0;
        seg = seg_tab[sh_dig[idx]];
        dp  = sh_dp[idx];
        if (sh_lz && idx != 0 && all_zero) seg = 7'h00;
        if (!phase_on && sh_blink[idx]) begin
            seg = 7'h00;
            dp  = 1'b0;
        end
        return {6'(1 << idx), dp, seg, frame};
    endfunction

    always @(negedge clk) begin
        logic [14:0] exp_v;
        logic [14:0] act_v;
        if (sb.size() > 0) begin
            exp_v = sb.pop_front();
            act_v = {o_seg_enb, o_seg_dp, o_seg, o_frame};
            total++;
            if (act_v !== exp_v) begin
                bad++;
                $display("FAIL out @%0t: got enb=%b dp=%b seg=%h frame=%b, want enb=%b dp=%b seg=%h frame=%b",
                         $time, act_v[14:9], act_v[8], act_v[7:1], act_v[0],
                         exp_v[14:9], exp_v[8], exp_v[7:1], exp_v[0]);
            end
        end
    end

    initial begin
        int rst_left;
        int lead;
        int idx;
        bit phase_on;
        bit frame;
        seg_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                    7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
        for (int k = 0; k < 6; k++) begin
            sh_dig[k] = 0; sh_dp[k] = 0; sh_blink[k] = 0;
        end
        sh_lz = 0;
        n = 0;
        pending = '0;
        pending_valid = 0;
        rst_left = 3;

        for (int c = 0; c < NCYC; c++) begin
            @(posedge clk);
            #1;
            if (pending_valid) sb.push_back(pending);

            // Drive this cycle's inputs; only snapshot cycles should matter.
            if (rst_left > 0) begin
                rst = 1'b1;
                rst_left--;
            end else begin
                rst = 1'b0;
                if (n > 30 && $urandom_range(0, 399) == 0)
                    rst_left = $urandom_range(1, 3);
            end
            lead = $urandom_range(0, 6);
            for (int k = 0; k < 6; k++) begin
                logic [3:0] nib;
                if (k >= 6 - lead) nib = 4'd0;
                else if ($urandom_range(0, 3) == 0) nib = 4'd0;
                else if ($urandom_range(0, 7) == 0) nib = 4'($urandom_range(10, 15));
                else nib = 4'($urandom_range(0, 9));
                i_digits[k*4 +: 4] = nib;
            end
            i_dp       = 6'($urandom);
            i_blink    = 6'($urandom);
            i_blank_lz = 1'($urandom);

            if (rst) begin
                pending = '0;
                n = 0;
                for (int k = 0; k < 6; k++) begin
                    sh_dig[k] = 0; sh_dp[k] = 0; sh_blink[k] = 0;
                end
                sh_lz = 0;
            end else begin
                idx      = (n / SD) % 6;
                phase_on = (((n / SD) / BD) % 2) == 0;
                frame    = (n % (6 * SD)) == 0;
                pending  = model_out(idx, phase_on, frame);
                if (frame) begin
                    for (int k = 0; k < 6; k++) begin
                        sh_dig[k]   = int'(i_digits[k*4 +: 4]);
                        sh_dp[k]    = i_dp[k];
                        sh_blink[k] = i_blink[k];
                    end
                    sh_lz = i_blank_lz;
                end
                n++;
            end
            pending_valid = 1;
        end

        repeat (2) @(negedge clk);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d entries left, want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
